// File: rtl/sdi_capture_ctrl_if.sv
// Video-in and frame-buffer write-port bundle for sdi_capture_ctrl.
// The capture controller is the slave side; the video source / frame buffer is the master side.
interface sdi_capture_ctrl_if #(
    parameter int ADDR_W = 21
);
    logic              i_sync_h;
    logic              i_sync_v;
    logic [9:0]        i_y;
    logic [9:0]        i_cb;
    logic [9:0]        i_cr;
    logic              i_wr_ready;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [29:0]       o_wr_data;

    modport slave (
        input  i_sync_h, i_sync_v, i_y, i_cb, i_cr, i_wr_ready,
        output o_wr_en, o_wr_addr, o_wr_data
    );

    modport master (
        output i_sync_h, i_sync_v, i_y, i_cb, i_cr, i_wr_ready,
        input  o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/sdi_capture_ctrl.sv
// Frame-capture controller: arms on command, waits for a clean start of frame, streams
// pixels linearly into the frame buffer and polices line length, line count and back-pressure.
module sdi_capture_ctrl #(
    parameter int IMG_W  = 1920,
    parameter int IMG_H  = 1080,
    parameter int ADDR_W = 21
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_continuous,
    input  logic              i_stop,
    input  logic              i_abort,
    sdi_capture_ctrl_if.slave bus,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [7:0]        o_frame_cnt,
    output logic              o_err_len,
    output logic              o_err_short,
    output logic              o_err_ovf
);

    localparam int PW = $clog2(IMG_W + 2);
    localparam int LW = $clog2(IMG_H + 1);
    localparam logic [PW-1:0]     PIX_FULL  = PW'(IMG_W);
    localparam logic [PW-1:0]     PIX_SAT   = PW'(IMG_W + 1);
    localparam logic [LW-1:0]     LINE_FULL = LW'(IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    typedef enum logic [2:0] {IDLE, ARM, WAIT_SOF, CAPTURE, FINISH} state_e;

    state_e            state_q, state_d;
    logic              cont_q, cont_d;
    logic              stop_pend_q, stop_pend_d;
    logic [PW-1:0]     pix_cnt_q, pix_cnt_d;
    logic [LW-1:0]     line_cnt_q, line_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [29:0]       wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              err_len_q, err_len_d;
    logic              err_short_q, err_short_d;
    logic              err_ovf_q, err_ovf_d;

    // Input pipe: pixel, syncs and ready are sampled together so ready belongs to its pixel.
    logic        sh_q, sv_q, sh_prev_q, sv_prev_q, rdy_q;
    logic [29:0] px_q;
    logic        sh_fall, sv_rise, sv_fall, line_open;

    assign sh_fall   = sh_prev_q && !sh_q;
    assign sv_rise   = !sv_prev_q && sv_q;
    assign sv_fall   = sv_prev_q && !sv_q;
    assign line_open = (line_cnt_q < LINE_FULL);

    always_ff @(posedge i_clk) begin
        // NOTE: every flop, input pipe included, is cleared so no stale pixel can turn into a write after reset.
        if (i_rst) begin
            state_q      <= IDLE;
            cont_q       <= 1'b0;
            stop_pend_q  <= 1'b0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            err_len_q    <= 1'b0;
            err_short_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
            sh_q         <= 1'b0;
            sv_q         <= 1'b0;
            sh_prev_q    <= 1'b0;
            sv_prev_q    <= 1'b0;
            rdy_q        <= 1'b0;
            px_q         <= '0;
        end else begin
            // NOTE: non-blocking everywhere here so every flop sees the pre-edge value of every other.
            state_q      <= state_d;
            cont_q       <= cont_d;
            stop_pend_q  <= stop_pend_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            err_len_q    <= err_len_d;
            err_short_q  <= err_short_d;
            err_ovf_q    <= err_ovf_d;
            sh_q         <= bus.i_sync_h;
            sv_q         <= bus.i_sync_v;
            sh_prev_q    <= sh_q;
            sv_prev_q    <= sv_q;
            rdy_q        <= bus.i_wr_ready;
            px_q         <= {bus.i_cr, bus.i_cb, bus.i_y};
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_d      = state_q;
        cont_d       = cont_q;
        stop_pend_d  = stop_pend_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        addr_d       = addr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        err_len_d    = err_len_q;
        err_short_d  = err_short_q;
        err_ovf_d    = err_ovf_q;

        if (i_abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    stop_pend_d = 1'b0;
                    if (i_start) begin
                        err_len_d   = 1'b0;
                        err_short_d = 1'b0;
                        err_ovf_d   = 1'b0;
                        frame_cnt_d = '0;
                        cont_d      = i_continuous;
                        state_d     = ARM;
                    end
                end
                ARM: begin
                    if (i_stop) begin
                        stop_pend_d = 1'b1;
                        state_d     = IDLE;
                    end else if (!sv_q) begin
                        state_d = WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    if (i_stop) begin
                        stop_pend_d = 1'b1;
                        state_d     = IDLE;
                    end else if (sv_rise) begin
                        pix_cnt_d  = '0;
                        line_cnt_d = '0;
                        addr_d     = '0;
                        state_d    = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (i_stop) stop_pend_d = 1'b1;
                    if (sh_q && line_open) begin
                        if (pix_cnt_q != PIX_SAT) pix_cnt_d = pix_cnt_q + 1'b1;
                        if (rdy_q) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = px_q;
                            if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
                        end else begin
                            err_ovf_d = 1'b1;
                        end
                    end
                    // Line check is resolved before the frame check so a coincident v-fall sees the final line count.
                    if (sh_fall) begin
                        if (line_open) begin
                            if (pix_cnt_q != PIX_FULL) err_len_d = 1'b1;
                            line_cnt_d = line_cnt_q + 1'b1;
                        end
                        pix_cnt_d = '0;
                    end
                    if (sv_fall) begin
                        if (line_cnt_d < LINE_FULL) err_short_d = 1'b1;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 1'b1;
                        state_d      = FINISH;
                    end
                end
                FINISH: begin
                    state_d = (!cont_q || stop_pend_q) ? IDLE : ARM;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy_d = (state_d != IDLE);

    assign bus.o_wr_en   = wr_en_q;
    assign bus.o_wr_addr = wr_addr_q;
    assign bus.o_wr_data = wr_data_q;
    assign o_busy        = busy_q;
    assign o_frame_done  = frame_done_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_err_len     = err_len_q;
    assign o_err_short   = err_short_q;
    assign o_err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_sdi_capture_ctrl.sv
// Directed bench for sdi_capture_ctrl on an 8x4 image: a vector table of single-shot frames
// plus hand-written sequences for latency, mid-field start, continuous/stop, abort and reset.
module tb_sdi_capture_ctrl;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 4;
    localparam int ADDR_W = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, cont = 1'b0, stop = 1'b0, abort = 1'b0;
    logic       busy, frame_done, err_len, err_short, err_ovf;
    logic [7:0] frame_cnt;

    sdi_capture_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    sdi_capture_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_continuous (cont),
        .i_stop       (stop),
        .i_abort      (abort),
        .bus          (bus),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_frame_cnt  (frame_cnt),
        .o_err_len    (err_len),
        .o_err_short  (err_short),
        .o_err_ovf    (err_ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0, n_done = 0, m_addr = 0;
    logic [ADDR_W-1:0] got_addr[$], exp_addr[$];
    logic [29:0]       got_data[$], exp_data[$];

    // Monitor: collect writes and frame_done pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.o_wr_en) begin
            got_addr.push_back(bus.o_wr_addr);
            got_data.push_back(bus.o_wr_data);
        end
        if (frame_done) n_done++;
    end

    typedef struct {
        int n_lines;  int sp_line; int sp_px;  int st_line; int st_px;
        int exp_wr;   int exp_last; bit exp_len; bit exp_short; bit exp_ovf;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [29:0] pix(input int fid, input int l, input int p);
        logic [9:0] y;
        y = 10'(fid * 64 + l * 8 + p + 1);
        return {y ^ 10'h155, ~y, y};
    endfunction

    task automatic clear_q();
        got_addr.delete(); got_data.delete();
        exp_addr.delete(); exp_data.delete();
        m_addr = 0;
    endtask

    task automatic do_start(input bit c);
        cont = c; start = 1'b1; tick();
        start = 1'b0; ticks(2);
    endtask

    task automatic drive_line(input int l, input int npx, input int st_px, input bit exp_cap,
                              input int fid, input int stop_px);
        for (int p = 0; p < npx; p++) begin
            bus.i_sync_h = 1'b1;
            {bus.i_cr, bus.i_cb, bus.i_y} = pix(fid, l, p);
            bus.i_wr_ready = (p != st_px);
            stop = (p == stop_px);
            if (exp_cap && (p != st_px) && l < IMG_H) begin
                exp_addr.push_back(ADDR_W'(m_addr));
                exp_data.push_back(pix(fid, l, p));
                m_addr++;
            end
            tick();
        end
        bus.i_sync_h = 1'b0; bus.i_wr_ready = 1'b1; stop = 1'b0;
        ticks(3);
    endtask

    task automatic run_frame(input int n_lines, input int sp_line, input int sp_px, input int st_line,
                             input int st_px, input int stop_line, input bit exp_cap, input int fid);
        bus.i_sync_v = 1'b1; m_addr = 0;
        ticks(2);
        for (int l = 0; l < n_lines; l++)
            drive_line(l, (l == sp_line) ? sp_px : IMG_W, (l == st_line) ? st_px : -1,
                       exp_cap, fid, (l == stop_line) ? 0 : -1);
        bus.i_sync_v = 1'b0;
        ticks(4);
    endtask

    task automatic compare_sb(input string tag);
        check({tag, " wr_count"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            check($sformatf("%s addr[%0d]", tag, i), got_addr[i], exp_addr[i]);
            check($sformatf("%s data[%0d]", tag, i), got_data[i], exp_data[i]);
        end
    endtask

    function automatic int last_addr();
        return (got_addr.size() > 0) ? int'(got_addr[got_addr.size()-1]) : -1;
    endfunction

    function automatic int first_addr();
        return (got_addr.size() > 0) ? int'(got_addr[0]) : -1;
    endfunction

    initial begin
        int n_at;
        bus.i_sync_h = 1'b0; bus.i_sync_v = 1'b0; bus.i_wr_ready = 1'b1;
        bus.i_y = '0; bus.i_cb = '0; bus.i_cr = '0;

        //            lines sp_l sp_px st_l st_px wr  last len sh  ovf
        vecs[0] = '{4,    1,   7,    2,   3,    30, 29,  1,  0,  1};
        vecs[1] = '{4,   -1,   0,   -1,   0,    32, 31,  0,  0,  0};
        vecs[2] = '{3,   -1,   0,   -1,   0,    24, 23,  0,  1,  0};
        vecs[3] = '{5,   -1,   0,   -1,   0,    32, 31,  0,  0,  0};
        vecs[4] = '{3,    0,   9,   -1,   0,    25, 24,  1,  1,  0};

        // Reset state
        ticks(3);
        check("rst wr_en", bus.o_wr_en, 0);
        check("rst wr_addr", bus.o_wr_addr, 0);
        check("rst wr_data", bus.o_wr_data, 0);
        check("rst busy", busy, 0);
        check("rst frame_cnt", frame_cnt, 0);
        check("rst errs", {err_len, err_short, err_ovf, frame_done}, 0);
        rst = 1'b0;
        tick();

        // Write latency: pixel sampled at edge N shows up after edge N+1
        clear_q(); n_done = 0;
        do_start(1'b0);
        check("start busy", busy, 1);
        bus.i_sync_v = 1'b1; ticks(2);
        bus.i_sync_h = 1'b1; {bus.i_cr, bus.i_cb, bus.i_y} = pix(7, 0, 0);
        tick();
        check("lat edgeN wr_en", bus.o_wr_en, 0);
        bus.i_sync_h = 1'b0;
        tick();
        check("lat edgeN1 wr_en", bus.o_wr_en, 1);
        check("lat edgeN1 addr", bus.o_wr_addr, 0);
        check("lat edgeN1 data", bus.o_wr_data, pix(7, 0, 0));
        ticks(2); bus.i_sync_v = 1'b0; ticks(4);
        check("lat err_len", err_len, 1);
        check("lat err_short", err_short, 1);
        check("lat frame_done", n_done, 1);

        // Single-shot vector table
        foreach (vecs[i]) begin
            clear_q(); n_done = 0;
            do_start(1'b0);
            run_frame(vecs[i].n_lines, vecs[i].sp_line, vecs[i].sp_px, vecs[i].st_line,
                      vecs[i].st_px, -1, 1'b1, i);
            ticks(2);
            compare_sb($sformatf("v%0d", i));
            check($sformatf("v%0d writes", i), got_addr.size(), vecs[i].exp_wr);
            check($sformatf("v%0d last_addr", i), last_addr(), vecs[i].exp_last);
            check($sformatf("v%0d err_len", i), err_len, vecs[i].exp_len);
            check($sformatf("v%0d err_short", i), err_short, vecs[i].exp_short);
            check($sformatf("v%0d err_ovf", i), err_ovf, vecs[i].exp_ovf);
            check($sformatf("v%0d frame_cnt", i), frame_cnt, 1);
            check($sformatf("v%0d frame_done", i), n_done, 1);
            check($sformatf("v%0d busy", i), busy, 0);
        end

        // Start in the middle of an active field: that field is skipped
        clear_q(); n_done = 0;
        bus.i_sync_v = 1'b1; ticks(2);
        drive_line(0, IMG_W, -1, 1'b0, 9, -1);
        do_start(1'b0);
        drive_line(1, IMG_W, -1, 1'b0, 9, -1);
        drive_line(2, IMG_W, -1, 1'b0, 9, -1);
        check("mid no_write", got_addr.size(), 0);
        check("mid armed busy", busy, 1);
        bus.i_sync_v = 1'b0; ticks(4);
        run_frame(4, -1, 0, -1, 0, -1, 1'b1, 10);
        ticks(2);
        compare_sb("mid");
        check("mid first_addr", first_addr(), 0);
        check("mid frame_cnt", frame_cnt, 1);
        check("mid frame_done", n_done, 1);

        // Stop while armed: idle next cycle, no frame_done
        n_done = 0;
        bus.i_sync_v = 1'b1; ticks(2);
        do_start(1'b0);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_arm busy", busy, 0);
        bus.i_sync_v = 1'b0; ticks(4);
        check("stop_arm frame_done", n_done, 0);

        // Continuous capture, stop during frame 3
        clear_q(); n_done = 0;
        do_start(1'b1);
        for (int f = 0; f < 3; f++) begin
            clear_q();
            run_frame(4, -1, 0, -1, 0, (f == 2) ? 1 : -1, 1'b1, 20 + f);
            compare_sb($sformatf("cont f%0d", f));
            check($sformatf("cont f%0d first_addr", f), first_addr(), 0);
            check($sformatf("cont f%0d frame_cnt", f), frame_cnt, f + 1);
            check($sformatf("cont f%0d busy", f), busy, (f < 2));
        end
        clear_q();
        run_frame(4, -1, 0, -1, 0, -1, 1'b0, 23);
        check("cont after_stop writes", got_addr.size(), 0);
        check("cont frame_cnt", frame_cnt, 3);
        check("cont frame_done", n_done, 3);

        // Abort mid-line 2: write strobe drops next cycle, errors retained
        clear_q(); n_done = 0;
        do_start(1'b0);
        bus.i_sync_v = 1'b1; ticks(2);
        drive_line(0, IMG_W, 2, 1'b1, 40, -1);
        for (int p = 0; p < 5; p++) begin
            bus.i_sync_h = 1'b1; {bus.i_cr, bus.i_cb, bus.i_y} = pix(40, 1, p);
            abort = (p == 4);
            tick();
        end
        abort = 1'b0;
        check("abort wr_en", bus.o_wr_en, 0);
        check("abort busy", busy, 0);
        for (int p = 5; p < IMG_W; p++) tick();
        bus.i_sync_h = 1'b0; ticks(3);
        bus.i_sync_v = 1'b0; ticks(4);
        check("abort writes", got_addr.size(), 10);
        check("abort last_addr", last_addr(), 9);
        check("abort err_ovf kept", err_ovf, 1);
        check("abort frame_done", n_done, 0);

        // Reset mid-capture in frame 2 of a continuous run
        clear_q(); n_done = 0;
        do_start(1'b1);
        run_frame(4, -1, 0, -1, 0, -1, 1'b1, 30);
        check("rstcap frame1_cnt", frame_cnt, 1);
        bus.i_sync_v = 1'b1; ticks(2);
        drive_line(0, IMG_W, 1, 1'b1, 31, -1);
        check("rstcap pre_ovf", err_ovf, 1);
        for (int p = 0; p < 4; p++) begin
            bus.i_sync_h = 1'b1; {bus.i_cr, bus.i_cb, bus.i_y} = pix(31, 1, p);
            rst = (p == 3);
            tick();
        end
        rst = 1'b0;
        n_at = got_addr.size();
        check("rstcap wr_en", bus.o_wr_en, 0);
        check("rstcap wr_addr", bus.o_wr_addr, 0);
        check("rstcap wr_data", bus.o_wr_data, 0);
        check("rstcap busy", busy, 0);
        check("rstcap frame_cnt", frame_cnt, 0);
        check("rstcap errs", {err_len, err_short, err_ovf, frame_done}, 0);
        for (int p = 4; p < IMG_W; p++) tick();
        bus.i_sync_h = 1'b0; ticks(3);
        drive_line(2, IMG_W, -1, 1'b0, 31, -1);
        bus.i_sync_v = 1'b0; ticks(4);
        check("rstcap no_write_after", got_addr.size(), n_at);
        check("rstcap idle", busy, 0);
        check("rstcap frame_done", n_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sdi_capture_ctrl.md
# sdi_capture_ctrl

Frame-capture controller placed after the SDI analysis stage. Takes the decoded active-video syncs and Y/Cb/Cr samples, and arms on a software command. It then waits for a clean start of frame and sequences linear pixel writes into the frame-buffer write port. It also polices line length, line count and write back-pressure, reporting sticky errors. It supports single-shot and continuous capture.

## Interface
- IMG_W, 1920, active pixels per line
- IMG_H, 1080, active lines per frame
- ADDR_W, 21, frame-buffer word address width (must satisfy 2^ADDR_W >= IMG_W*IMG_H)
- i_clk  in  1  video clock
- i_rst  in  1  reset: synchronous, active-high
- i_start  in  1  one-cycle capture command
- i_continuous  in  1  sampled at i_start: 1 = capture every frame until stopped
- i_stop  in  1  one-cycle request: finish current frame, then idle
- i_abort  in  1  one-cycle request: idle immediately
- i_sync_h  in  1  high during active pixels of a line
- i_sync_v  in  1  high during active field
- i_y, i_cb, i_cr  in  10 each  pixel components, valid when i_sync_h=1
- i_wr_ready  in  1  frame-buffer port can accept a write this cycle
- o_wr_en  out  1  write strobe
- o_wr_addr  out  ADDR_W  word address
- o_wr_data  out  30  {cr, cb, y}
- o_busy  out  1  state != IDLE
- o_frame_done  out  1  one-cycle pulse per completed frame
- o_frame_cnt  out  8  frames completed since i_start, wraps 255->0
- o_err_len  out  1  sticky: a line had pixel count != IMG_W
- o_err_short  out  1  sticky: frame ended with fewer than IMG_H lines
- o_err_ovf  out  1  sticky: pixel dropped because i_wr_ready=0

## Operation
- FSM states: IDLE, ARM, WAIT_SOF, CAPTURE, FINISH.
- IDLE: on i_start, clear all sticky errors and o_frame_cnt, latch i_continuous, then go to ARM. i_start is ignored in every other state.
- ARM: wait for i_sync_v=0, so capture never begins mid-frame. Then go to WAIT_SOF.
- WAIT_SOF: on a rising edge of i_sync_v (registered previous value 0, current 1), reset the pixel counter, line counter and address to 0, then go to CAPTURE.
- CAPTURE, each cycle with i_sync_h=1 and line count < IMG_H:
  - if i_wr_ready=1, issue a write and increment the address;
  - else drop the pixel, set o_err_ovf, and leave the address unchanged.
  - The pixel counter increments in both cases.
- CAPTURE, falling edge of i_sync_h:
  - if pixel count != IMG_W, set o_err_len;
  - increment the line count (saturates at IMG_H) and clear the pixel counter.
- Active pixels arriving after IMG_H lines are ignored: no write, no error.
- CAPTURE to FINISH on a falling edge of i_sync_v. If line count < IMG_H at that point, set o_err_short.
- FINISH (one cycle):
  - pulse o_frame_done and increment o_frame_cnt;
  - go to IDLE if continuous=0 or a stop is pending, else go to ARM.
- i_stop in ARM, WAIT_SOF or CAPTURE sets a pending-stop flag, cleared in IDLE. i_stop in ARM or WAIT_SOF goes to IDLE on the next cycle with no frame_done.
- i_abort, any state: next cycle IDLE. o_wr_en=0 from that cycle, no o_frame_done, sticky errors retained.
- Simultaneous events:
  - i_abort beats i_stop and i_start.
  - A falling edge of i_sync_h coinciding with a falling edge of i_sync_v completes the line check first, then the frame check.
- An address at IMG_W*IMG_H-1 does not advance further (IMG_H cap guarantees this).

## Timing
- Reset: state IDLE; all outputs 0, including o_wr_addr, o_wr_data and o_frame_cnt.
- Write latency: pixel sampled at edge N appears on o_wr_en/addr/data after edge N+1. All outputs are registered.
- i_wr_ready is sampled in the same cycle as the pixel, not the output cycle. The frame buffer must accept any write it flagged ready for.
- o_frame_done is asserted in the cycle after the i_sync_v falling edge is detected.
- o_busy goes high the cycle after i_start and low the cycle after FINISH or abort.
- Reset mid-capture: next cycle all state and outputs return to reset values. No partial write is issued after reset.

## Test plan
- IMG_W=8, IMG_H=4, single shot, i_start in blanking, one clean frame → 32 writes at addresses 0..31 with matching {cr,cb,y}, one o_frame_done, o_frame_cnt=1, no errors, o_busy returns 0.
- i_start mid-active-field → no writes until the next field; capture starts at the following rising edge of i_sync_v at address 0.
- Line 2 with 7 pixels, and i_wr_ready=0 for one pixel on line 3 → o_err_len=1, o_err_ovf=1, 30 writes total, last address 29.
- i_sync_v falls after 3 lines → o_err_short=1, 24 writes, frame_done pulses.
- Continuous mode, 3 frames, i_stop during frame 3 → frame_cnt=3, idle after frame 3. Addresses restart at 0 each frame.
- i_abort mid-line 2, plus i_rst mid-capture in a separate run → o_wr_en low from the next cycle, state IDLE. For abort, errors are retained; for reset, all outputs are 0.
